// File: rtl/image_pipe_arb_pkg.sv
// Shared types for the two-source frame arbiter.
//   arb_state_t : arbiter FSM encoding
//   NUM_SRC     : number of upstream image sources
package image_pipe_arb_pkg;

   typedef enum logic [1:0] {IDLE, GRANT, DRAIN} arb_state_t;

   localparam int NUM_SRC = 2;

endpackage

// File: rtl/image_pipe_skid.sv
// Registered output stage with a one-entry skid buffer.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   in_valid/in_data: beat being written this cycle (caller guarantees the
//                     skid entry is free whenever in_valid is high)
//   out_busy        : downstream stall
//   out_valid/data  : registered output beat
//   out_valid_nxt   : output register occupancy after this edge
//   skid_valid_nxt  : skid entry occupancy after this edge
module image_pipe_skid #(
   parameter int W = 33
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   input  logic         out_busy,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   output logic         out_valid_nxt,
   output logic         skid_valid_nxt
);

   logic         out_valid_q, out_valid_d;
   logic [W-1:0] out_data_q, out_data_d;
   logic         skid_valid_q, skid_valid_d;
   logic [W-1:0] skid_data_q, skid_data_d;
   logic         consume;

   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      consume      = out_valid_q && !out_busy;

      if (consume) begin
         if (skid_valid_q) begin
            out_data_d   = skid_data_q;
            skid_valid_d = 1'b0;
         end else begin
            out_valid_d  = 1'b0;
         end
      end

      // After the consume step, the write lands in the output register if
      // it is free, otherwise it parks in the skid entry.
      if (in_valid) begin
         if (!out_valid_d) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data;
         end else begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
      end
   end

   assign out_valid      = out_valid_q;
   assign out_data       = out_data_q;
   assign out_valid_nxt  = out_valid_d;
   assign skid_valid_nxt = skid_valid_d;

endmodule

// File: rtl/image_pipe_arb.sv
// Two-source frame arbiter in front of image_pipe. Grants whole frames,
// alternating round-robin, through a registered output with a skid entry.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   src_*_in[0:1]         : per-source beat data / valid / end
//   src_busy_out[0:1]     : registered per-source stall
//   arb_data/valid/end_out: beat stream toward image_pipe
//   arb_busy_in           : stall from image_pipe
//   arb_grant_out         : one-hot owner of the current frame, 0 when idle
//   frame_cnt_out[0:1]    : completed frames per source (wrapping)
//
// state | meaning
// IDLE  | no owner; waiting for any source valid
// GRANT | owner's beats accepted until its end beat
// DRAIN | end beat accepted; waiting for output and skid to empty
module image_pipe_arb
   import image_pipe_arb_pkg::*;
#(
   parameter int DW    = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [DW-1:0]    src_data_in   [0:1],
   input  logic             src_valid_in  [0:1],
   input  logic             src_end_in    [0:1],
   output logic             src_busy_out  [0:1],
   output logic [DW-1:0]    arb_data_out,
   output logic             arb_valid_out,
   output logic             arb_end_out,
   input  logic             arb_busy_in,
   output logic [1:0]       arb_grant_out,
   output logic [CNT_W-1:0] frame_cnt_out [0:1]
);

   arb_state_t         state_q, state_d;
   logic [1:0]         grant_q, grant_d;
   logic               last_q, last_d;
   logic [NUM_SRC-1:0] busy_q, busy_d;
   logic [CNT_W-1:0]   cnt_q [0:NUM_SRC-1];
   logic [CNT_W-1:0]   cnt_d [0:NUM_SRC-1];

   logic               g;
   logic               pick;
   logic               acc;
   logic [DW:0]        acc_beat;
   logic [DW:0]        out_beat;
   logic               out_valid_nxt;
   logic               skid_valid_nxt;

   assign g = grant_q[1];

   // Only the owner can see busy low, and only while in GRANT.
   always_comb begin
      acc      = 1'b0;
      acc_beat = '0;
      if (state_q == GRANT && src_valid_in[g] && !busy_q[g]) begin
         acc      = 1'b1;
         acc_beat = {src_end_in[g], src_data_in[g]};
      end
   end

   image_pipe_skid #(.W(DW + 1)) u_skid (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (acc),
      .in_data        (acc_beat),
      .out_busy       (arb_busy_in),
      .out_valid      (arb_valid_out),
      .out_data       (out_beat),
      .out_valid_nxt  (out_valid_nxt),
      .skid_valid_nxt (skid_valid_nxt)
   );

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      pick    = 1'b0;

      case (state_q)
         IDLE: begin
            if (src_valid_in[0] || src_valid_in[1]) begin
               if (src_valid_in[0] && src_valid_in[1]) pick = ~last_q;
               else                                    pick = src_valid_in[1];
               grant_d = pick ? 2'b10 : 2'b01;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (acc && acc_beat[DW]) state_d = DRAIN;
         end
         DRAIN: begin
            // Leave as soon as the end beat is consumed this cycle so the
            // next grant can land two cycles after that consume.
            if (!out_valid_nxt && !skid_valid_nxt) begin
               cnt_d[g] = cnt_q[g] + CNT_W'(1);
               last_d   = g;
               grant_d  = 2'b00;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      for (int i = 0; i < NUM_SRC; i++) begin
         busy_d[i] = !(state_d == GRANT && grant_d[i] && !skid_valid_nxt);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= 2'b00;
         last_q  <= 1'b1;
         busy_q  <= '0;
         for (int i = 0; i < NUM_SRC; i++) cnt_q[i] <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_SRC; i++) begin
         src_busy_out[i]  = busy_q[i];
         frame_cnt_out[i] = cnt_q[i];
      end
   end

   assign arb_grant_out = grant_q;
   assign arb_data_out  = out_beat[DW-1:0];
   assign arb_end_out   = arb_valid_out & out_beat[DW];

endmodule

// File: tb/tb_image_pipe_arb.sv
// Self-checking bench for image_pipe_arb (CNT_W = 2 so wrap is reachable).
// Model: per-source queues of expected beats; each output frame's owner is
// chosen by the round-robin rule over sources with pending frames.
module tb_image_pipe_arb;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] src_data_in  [0:1];
   logic        src_valid_in [0:1];
   logic        src_end_in   [0:1];
   logic        src_busy_out [0:1];
   logic [31:0] arb_data_out;
   logic        arb_valid_out;
   logic        arb_end_out;
   logic        arb_busy_in;
   logic [1:0]  arb_grant_out;
   logic [1:0]  frame_cnt_out [0:1];

   image_pipe_arb #(.DW(32), .CNT_W(2)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .src_data_in   (src_data_in),
      .src_valid_in  (src_valid_in),
      .src_end_in    (src_end_in),
      .src_busy_out  (src_busy_out),
      .arb_data_out  (arb_data_out),
      .arb_valid_out (arb_valid_out),
      .arb_end_out   (arb_end_out),
      .arb_busy_in   (arb_busy_in),
      .arb_grant_out (arb_grant_out),
      .frame_cnt_out (frame_cnt_out)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // driver queues (what each source still has to present) and model queues
   logic [32:0] dq0[$], dq1[$], mq0[$], mq1[$];

   function automatic int dsize(int i);
      return (i == 0) ? dq0.size() : dq1.size();
   endfunction
   function automatic int msize(int i);
      return (i == 0) ? mq0.size() : mq1.size();
   endfunction
   function automatic logic [32:0] dfront(int i);
      return (i == 0) ? dq0[0] : dq1[0];
   endfunction
   function automatic logic [32:0] mfront(int i);
      return (i == 0) ? mq0[0] : mq1[0];
   endfunction
   function automatic void dpop(int i);
      if (i == 0) void'(dq0.pop_front()); else void'(dq1.pop_front());
   endfunction
   function automatic void mpop(int i);
      if (i == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
   endfunction

   task automatic send_frame(input int s, input logic [31:0] base, input int n);
      logic [32:0] b;
      for (int k = 0; k < n; k++) begin
         b = {(k == n - 1) ? 1'b1 : 1'b0, base + 32'(k)};
         if (s == 0) begin dq0.push_back(b); mq0.push_back(b); end
         else        begin dq1.push_back(b); mq1.push_back(b); end
      end
   endtask

   // source drivers: hold each beat until accepted
   initial begin
      logic [32:0] b;
      for (int i = 0; i < 2; i++) begin
         src_valid_in[i] = 1'b0;
         src_data_in[i]  = '0;
         src_end_in[i]   = 1'b0;
      end
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
               if (i == 0) dq0.delete(); else dq1.delete();
            end else if (src_valid_in[i] && !src_busy_out[i]) begin
               dpop(i);
            end
         end
         @(posedge clk);
         #2;
         for (int i = 0; i < 2; i++) begin
            if (rst_n && dsize(i) > 0) begin
               b = dfront(i);
               src_valid_in[i] = 1'b1;
               src_data_in[i]  = b[31:0];
               src_end_in[i]   = b[32];
            end else begin
               src_valid_in[i] = 1'b0;
               src_end_in[i]   = 1'b0;
            end
         end
      end
   end

   // model + compare
   int          cyc = 0;
   int          cur = -1;
   int          last = 1;
   int          mcnt [2] = '{0, 0};
   bit          pend_log = 1'b0;
   int          log_src = 0;
   int          start_cyc = 0;
   logic [1:0]  grant_log[$];
   int          cnt_log[$];
   int          dur_log[$];

   initial begin
      logic [32:0] e;
      int p;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            mq0.delete(); mq1.delete();
            cur = -1; last = 1; mcnt[0] = 0; mcnt[1] = 0; pend_log = 1'b0;
         end else begin
            if (pend_log) begin
               cnt_log.push_back(int'(frame_cnt_out[log_src]));
               pend_log = 1'b0;
            end
            for (int i = 0; i < 2; i++) chk("frame_cnt", frame_cnt_out[i], 64'(mcnt[i] % 4));
            if (arb_valid_out) begin
               if (cur < 0) begin
                  if (msize(0) > 0 && msize(1) > 0) p = 1 - last;
                  else if (msize(0) > 0)            p = 0;
                  else if (msize(1) > 0)            p = 1;
                  else                              p = -1;
                  if (p < 0) chk("unexpected_beat", arb_valid_out, 0);
                  else begin
                     cur = p;
                     start_cyc = cyc;
                     grant_log.push_back(arb_grant_out);
                  end
               end
               if (cur >= 0) begin
                  e = mfront(cur);
                  chk("grant", arb_grant_out, (cur == 0) ? 2'b01 : 2'b10);
                  chk("data", arb_data_out, e[31:0]);
                  chk("end", arb_end_out, e[32]);
                  chk("busy_other", src_busy_out[1 - cur], 1'b1);
                  if (!arb_busy_in) begin
                     mpop(cur);
                     if (e[32]) begin
                        mcnt[cur]++;
                        last = cur;
                        pend_log = 1'b1;
                        log_src = cur;
                        dur_log.push_back(cyc - start_cyc + 1);
                        cur = -1;
                     end
                  end
               end
            end
         end
      end
   end

   task automatic chk_zero(input string nm);
      chk({nm, "_valid"}, arb_valid_out, 0);
      chk({nm, "_data"},  arb_data_out, 0);
      chk({nm, "_end"},   arb_end_out, 0);
      chk({nm, "_grant"}, arb_grant_out, 0);
      chk({nm, "_busy0"}, src_busy_out[0], 0);
      chk({nm, "_busy1"}, src_busy_out[1], 0);
      chk({nm, "_cnt0"},  frame_cnt_out[0], 0);
      chk({nm, "_cnt1"},  frame_cnt_out[1], 0);
   endtask

   task automatic do_reset(input string nm);
      @(posedge clk); #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 chk_zero(nm);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      grant_log.delete(); cnt_log.delete(); dur_log.delete();
   endtask

   task automatic wait_done(input string nm);
      int t = 0;
      while (t < 400 && (dsize(0) + dsize(1) + msize(0) + msize(1) != 0 || cur >= 0)) begin
         @(negedge clk); #1;
         t++;
      end
      chk({"drained_", nm}, 64'(msize(0) + msize(1)), 0);
      repeat (3) @(negedge clk);
      #1;
   endtask

   task automatic wait_beat(input string nm, input logic [31:0] d);
      int t = 0;
      bit ok = 1'b0;
      while (t < 100 && !ok) begin
         @(negedge clk);
         ok = arb_valid_out && arb_data_out == d;
         t++;
      end
      chk({"seen_", nm}, ok, 1'b1);
   endtask

   initial begin
      int t;
      int exp_wrap [5] = '{1, 2, 3, 0, 1};
      logic [1:0] exp_fair [4] = '{2'b01, 2'b10, 2'b01, 2'b01};
      arb_busy_in = 1'b0;

      // single source, latency and throughput
      do_reset("rst1");
      send_frame(0, 32'h10, 4);
      t = 0;
      do begin @(negedge clk); t++; end while (!src_valid_in[0] && t < 50);
      chk("t1_grant_pre", arb_grant_out, 2'b00);
      @(negedge clk);
      chk("t1_grant", arb_grant_out, 2'b01);
      chk("t1_busy_fall", src_busy_out[0], 1'b0);
      @(negedge clk);
      chk("t1_first_out", {arb_valid_out, arb_data_out}, {1'b1, 32'h10});
      wait_done("t1");
      chk("t1_cnt0", frame_cnt_out[0], 1);
      chk("t1_cnt1", frame_cnt_out[1], 0);
      chk("t1_frames", 64'(dur_log.size()), 1);
      if (dur_log.size() > 0) chk("t1_dur", 64'(dur_log[0]), 4);

      // tie after reset: source 0 first
      do_reset("rst2");
      send_frame(0, 32'h20, 3);
      send_frame(1, 32'h30, 2);
      wait_done("t2");
      chk("t2_nframes", 64'(grant_log.size()), 2);
      if (grant_log.size() == 2) begin
         chk("t2_first", grant_log[0], 2'b01);
         chk("t2_second", grant_log[1], 2'b10);
      end
      chk("t2_cnt0", frame_cnt_out[0], 1);
      chk("t2_cnt1", frame_cnt_out[1], 1);

      // backpressure: 3 busy cycles mid-frame
      do_reset("rst3");
      send_frame(0, 32'hA0, 8);
      wait_beat("a2", 32'hA2);
      @(posedge clk); #1 arb_busy_in = 1'b1;
      repeat (3) @(posedge clk);
      #1 arb_busy_in = 1'b0;
      wait_done("t3");
      chk("t3_frames", 64'(dur_log.size()), 1);
      if (dur_log.size() > 0) chk("t3_dur", 64'(dur_log[0]), 11);
      chk("t3_cnt0", frame_cnt_out[0], 1);

      // fairness: order 0,1,0,0
      do_reset("rst4");
      send_frame(0, 32'h40, 2);
      send_frame(0, 32'h42, 2);
      send_frame(0, 32'h44, 2);
      send_frame(1, 32'h60, 2);
      wait_done("t4");
      chk("t4_nframes", 64'(grant_log.size()), 4);
      for (int k = 0; k < grant_log.size() && k < 4; k++) chk("t4_order", grant_log[k], exp_fair[k]);
      chk("t4_cnt0", frame_cnt_out[0], 3);
      chk("t4_cnt1", frame_cnt_out[1], 1);

      // counter wrap with single-beat frames from source 1
      do_reset("rst5");
      for (int k = 0; k < 5; k++) send_frame(1, 32'h70 + 32'(k), 1);
      wait_done("t5");
      chk("t5_nlog", 64'(cnt_log.size()), 5);
      for (int k = 0; k < cnt_log.size() && k < 5; k++) chk("t5_wrap", 64'(cnt_log[k]), 64'(exp_wrap[k]));
      for (int k = 0; k < grant_log.size(); k++) chk("t5_grant", grant_log[k], 2'b10);

      // reset mid-frame, then a clean frame
      do_reset("rst6");
      send_frame(0, 32'h50, 6);
      wait_beat("b51", 32'h51);
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); #1 chk_zero("t6_mid");
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      grant_log.delete(); cnt_log.delete(); dur_log.delete();
      send_frame(1, 32'h80, 3);
      wait_done("t6");
      chk("t6_cnt1", frame_cnt_out[1], 1);
      chk("t6_cnt0", frame_cnt_out[0], 0);
      chk("t6_nframes", 64'(grant_log.size()), 1);
      if (grant_log.size() > 0) chk("t6_grant", grant_log[0], 2'b10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish (errors=%0d checks=%0d)", errors, checks);
      $fatal(1);
   end

endmodule

// File: doc/image_pipe_arb.md
# image_pipe_arb

Two-source frame arbiter in front of `image_pipe`. It shares the single `image_pipe` input stream between two upstream image sources and grants whole frames, never single beats. A source keeps the grant from its first accepted beat until its end-flagged beat has left the arbiter. Grants alternate round-robin, and the output stage is registered with a one-entry skid buffer so that every busy output is a flop.

## Interface
Parameters:
- `DW`, 32, data width of each source and of the output.
- `CNT_W`, 16, width of the per-source completed-frame counters.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst_n`  in  1  synchronous, active-low reset.
- `src_data_in[0:1]`  in  DW each  source beat data.
- `src_valid_in[0:1]`  in  1 each  beat valid.
- `src_end_in[0:1]`  in  1 each  marks the last beat of a frame; qualified by valid.
- `src_busy_out[0:1]`  out  1 each  registered; source must not present a new beat while this is 1.
- `arb_data_out`  out  DW  to `image_pipe_data_in`.
- `arb_valid_out`  out  1  to `image_pipe_valid_in`.
- `arb_end_out`  out  1  to `image_pipe_end_in`; high together with the last beat.
- `arb_busy_in`  in  1  from `image_pipe_busy_out`.
- `arb_grant_out`  out  2  one-hot current grant; 0 when idle.
- `frame_cnt_out[0:1]`  out  CNT_W each  frames completed per source.

## Operation
- **Source beat accept:** a beat from source i is accepted on a cycle where `src_valid_in[i] && !src_busy_out[i]`.
- **Output beat consume:** an output beat is consumed on a cycle where `arb_valid_out && !arb_busy_in`. Outputs hold while `arb_busy_in` is 1.
- **src_busy_out[i] is 1 when:**
  - source i is not granted, or
  - the skid entry is valid (or becomes valid this cycle), or
  - the state is not GRANT.
- **Data path:** an accepted beat goes to the output register if that register is empty or being consumed; otherwise it goes to the skid entry. The skid entry moves to the output register when the output beat is consumed.
- **IDLE:** wait for any `src_valid_in`. If one source is requesting, grant it. If both are requesting, grant the source that is not `last_grant`. `last_grant` resets to 1, so source 0 wins the first tie. Go to GRANT.
- **GRANT:** accept beats from the granted source only. When the end-flagged beat is accepted, go to DRAIN.
- **DRAIN:** wait until both the output register and the skid entry are empty, i.e. the end beat has been consumed. Then:
  - increment `frame_cnt_out[g]` (wraps modulo 2^CNT_W);
  - set `last_grant` to g and `arb_grant_out` to 0;
  - go to IDLE.
- **Valid without end:** valid beats with `src_end_in` low keep the frame open indefinitely. There is no timeout.
- **Non-granted source:** `src_valid_in` from the non-granted source is ignored; that source holds its beat.
- **Single-beat frame:** a frame whose first beat carries end is legal. The path is IDLE→GRANT→DRAIN.

## Timing
- **Reset values:** all outputs 0, including `src_busy_out` and `frame_cnt_out`. State IDLE, skid empty, `last_grant` = 1.
- **Grant latency:** the grant is registered. With a request in IDLE at cycle n:
  - `arb_grant_out` and state GRANT at n+1;
  - `src_busy_out` of the granted source falls at n+1;
  - the first beat can be accepted at n+1 and appears on `arb_*_out` at n+2.
- **Throughput:** steady state is 1 beat per cycle with latency 1.
- **Backpressure:** `arb_busy_in` rising at cycle n means the beat accepted at n goes to the skid entry. `src_busy_out` is 1 from n+1. No beat is lost or duplicated.
- **Turnaround:** from end-beat consumption at cycle m, DRAIN exits at m+1. The next grant is at m+2 at the earliest, leaving at least one bubble cycle between frames.
- **Simultaneous events:** a skid refill and an output consume in the same cycle are legal.
- **Reset mid-frame:** state, skid, outputs and counters are cleared on the next edge. There is no partial-frame recovery.

## Structure
- Package `image_pipe_arb_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, GRANT, DRAIN} arb_state_t`;
  - `localparam NUM_SRC = 2`.
- Sub-module `image_pipe_skid`, parameterized by `DW+1` (data plus end), containing:
  - the output register and one skid entry;
  - the valid/busy logic.
- Top level contains the FSM, the round-robin pointer, the input mux and the counters.

## Test plan
- **Single source:** source 0 sends a 4-beat frame 0x10..0x13 with end on 0x13, `arb_busy_in`=0. Expect:
  - `arb_grant_out`=01 one cycle after the first valid;
  - output 0x10..0x13 on consecutive cycles, with `arb_end_out` only with 0x13;
  - `frame_cnt_out[0]`=1.
- **Tie:** both sources request at the same cycle after reset. Expect:
  - source 0's frame completes entirely before source 1 is granted;
  - source 1 is granted next;
  - `frame_cnt` values 1/1.
- **Backpressure:** hold `arb_busy_in` high for 3 cycles mid-frame while beats 0xA0..0xA7 stream. Expect:
  - exactly 0xA0..0xA7 out, in order, with no gaps other than the busy cycles;
  - the skid entry is used exactly once per busy edge.
- **Fairness:** source 0 requests continuously for 3 frames while source 1 requests once. Expect the grant order 0,1,0,0.
- **Counter wrap:** `CNT_W`=2, five frames from source 1. Expect `frame_cnt_out[1]` to read 1,2,3,0,1.
- **Reset mid-frame:** assert `rst_n` low for 1 cycle during beat 2 of a frame. Expect:
  - all outputs 0 on the next edge;
  - a new frame afterwards passes cleanly with `frame_cnt_out`=1 for its source.
